ac97_record_rx: RTL and testbench
=================================

Name: ac97_record_rx

Overview:
- Receive-side deserializer for the AC97 link: samples SData_In framing from the codec and recovers the slot-0 tag, status registers (slots 1/2) and PCM record samples (slots 3/4).
- Mirror of the playback serializer. Sits beside the codec interface and feeds PCM_Record_Left/Right/Valid to recording or loopback logic.
- Single clock domain (system clk). The bit-clock sample point arrives as a one-cycle strobe, bit_en.

Parameters:
- SAMPLE_BITS, 16: PCM output width; taken from the MSBs of each 20-bit slot (legal range 16..20).
- REQUIRE_BOTH, 1: 1 = pcm_valid only when both slot-3 and slot-4 tag bits are set; 0 = either slot alone suffices (the missing channel holds its previous value).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low.
- bit_en, input, 1: one-cycle strobe at each falling-edge sample point of BIT_CLK.
- sync, input, 1: AC97 Sync, already synchronized to clk.
- sdata_in, input, 1: AC97 SData_In, already synchronized to clk.
- codec_ready, output, 1: tag bit 15 of the last complete slot 0.
- pcm_left, output, SAMPLE_BITS: slot-3 sample.
- pcm_right, output, SAMPLE_BITS: slot-4 sample.
- pcm_valid, output, 1: one-clk pulse when a new sample pair is published.
- status_addr, output, 7: slot-1 bits 18:12.
- status_data, output, 16: slot-2 bits 19:4.
- status_valid, output, 1: one-clk pulse when status is published.
- sync_err, output, 1: one-clk pulse on a framing violation.
- in_frame, output, 1: high while the block is locked to framing.

Behaviour:
- Reset: all outputs 0; state HUNT; bit counter 0; prev_sync 0.
- All sampling happens only on clk edges where bit_en=1. Between strobes all state holds.
- Frame start: sampled sync=1 with prev_sync=0. The bit sampled on that strobe is frame bit 0, the tag MSB.
- Frame layout, MSB first:
  - bits 0-15: tag.
  - slot n (1..12): bits 16+20(n-1) .. 35+20(n-1).
  - frame length: 256 bits.
- States:
  - HUNT: ignore data until a frame start, then load bit counter=1, shift in bit 0, go LOCKED.
  - LOCKED: shift sdata_in into the slot shift register and increment the counter (8-bit; wraps 255->0).
- Tag latch: at bit 15, latch tag[15:3] internally. codec_ready updates at the same time.
- Slot 1 end (bit 35): latch status_addr candidate if tag[14]=1.
- Slot 2 end (bit 55): if tag[13]=1 and tag[14]=1, publish status_addr and status_data, and pulse status_valid the following clk.
- Slot 3 end (bit 75): capture left candidate = slot[19:20-SAMPLE_BITS].
- Slot 4 end (bit 95): capture right candidate.
- PCM publish, evaluated at bit 95:
  - REQUIRE_BOTH=1: if tag[12]&tag[11], pcm_left/pcm_right update together and pcm_valid pulses the following clk.
  - REQUIRE_BOTH=0: update the channel(s) whose tag bit is set, and pulse if either is set.
- Tag-bit gating: a slot whose tag bit is 0 never alters outputs.
- Publish latency: outputs update 1 clk after the bit_en that sampled the slot's last bit; the valid pulse is aligned with that update.
- Slots 5-12 are shifted in and discarded.
- Framing checks:
  - Expected boundary: at counter=0 (after bit 255) a frame start is expected on that strobe.
  - Missing sync rise at the boundary: pulse sync_err, go HUNT, in_frame=0.
  - Sync rise with counter≠0: pulse sync_err, treat it as a new frame start (counter=1, capture bit 0), stay LOCKED. Partially received slots are dropped and no publish occurs for them.
- in_frame = (state==LOCKED).
- Reset mid-frame: immediate return to the reset state. No pulse is emitted even if a publish was pending.
- sync_err may pulse on the same clk as a pending pcm_valid from the previous bit. Both are independent.

Decomposition:
- Package ac97_pkg holds:
  - FRAME_BITS=256, TAG_BITS=16, SLOT_BITS=20.
  - Slot-end bit indices (35, 55, 75, 95).
  - Tag bit positions: READY=15, SLOT1=14, SLOT2=13, SLOT3=12, SLOT4=11.
  - State enum {HUNT, LOCKED}.
- One natural sub-module, ac97_slot_shifter: 20-bit MSB-first shift register with a bit_en gate. Position decode stays in the top level.

Test Plan:
- Reset/idle: hold reset low 3 clks with toggling sdata_in/sync -> all outputs 0 and in_frame=0. After release with sync=0 for 300 strobes, there is no pulse.
- Nominal frame, bit_en every 4 clks:
  - Stimulus: tag=16'hF800, slot1=20'h26000, slot2=20'h12340, slot3=20'hABCD0, slot4=20'h12345.
  - Response: codec_ready=1; status_addr=7'h26, status_data=16'h1234; status_valid pulses once.
  - Response: pcm_left=16'hABCD, pcm_right=16'h1234; pcm_valid pulses exactly once, 1 clk after the bit-95 strobe.
- Partial tag, tag=16'h9000 (ready + slot3 only):
  - REQUIRE_BOTH=1: no pcm_valid and outputs unchanged.
  - REQUIRE_BOTH=0: pcm_left updates, pcm_right holds, one pcm_valid.
- Early sync: sync rises at bit 120 -> sync_err pulses once, counter restarts, the next 256-bit frame decodes correctly, in_frame stays 1.
- Missing sync: no sync rise at bit 256 -> sync_err pulse, in_frame=0. A later valid frame relocks and publishes.
- Reset mid-frame: assert reset at bit 80 of a fully tagged frame -> outputs 0 asynchronously, no pcm_valid, HUNT. The next full frame decodes correctly.

Source files
------------

// File: rtl/ac97_pkg.sv
// ============================================================================
// Module   : ac97_pkg
// Purpose  : Shared frame geometry, slot-end positions, tag bits and state type
// Revision : 1.0
// ============================================================================
`default_nettype none

package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] TAG_END   = 8'd15;
    localparam logic [CNT_W-1:0] SLOT1_END = 8'd35;
    localparam logic [CNT_W-1:0] SLOT2_END = 8'd55;
    localparam logic [CNT_W-1:0] SLOT3_END = 8'd75;
    localparam logic [CNT_W-1:0] SLOT4_END = 8'd95;

    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ac97_record_rx_slot_shifter.sv
// ============================================================================
// Module   : ac97_slot_shifter
// Purpose  : MSB-first slot shift register; shift_next includes the bit being sampled
// Revision : 1.0
// ============================================================================
`default_nettype none

module ac97_slot_shifter
    import ac97_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_en,
    input  logic                 din,
    output logic [SLOT_BITS-1:0] shift_next
);

    // Only the previous 19 bits need storage; the newest bit comes straight from din.
    logic [SLOT_BITS-2:0] shift_q;
    logic [SLOT_BITS-2:0] shift_d;

    assign shift_next = {shift_q, din};

    always_comb begin
        shift_d = shift_q;
        if (bit_en) begin
            shift_d = shift_next[SLOT_BITS-2:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ac97_record_rx.sv
// ============================================================================
// Module   : ac97_record_rx
// Purpose  : AC97 SData_In deserializer recovering tag, status and PCM record slots
// Revision : 1.0
// ============================================================================
`default_nettype none

module ac97_record_rx
    import ac97_pkg::*;
#(
    parameter int SAMPLE_BITS  = 16,
    parameter int REQUIRE_BOTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_en,
    input  logic                   sync,
    input  logic                   sdata_in,
    output logic                   codec_ready,
    output logic [SAMPLE_BITS-1:0] pcm_left,
    output logic [SAMPLE_BITS-1:0] pcm_right,
    output logic                   pcm_valid,
    output logic [6:0]             status_addr,
    output logic [15:0]            status_data,
    output logic                   status_valid,
    output logic                   sync_err,
    output logic                   in_frame
);

    logic [SLOT_BITS-1:0] shift_next;
    logic                 unused_bits;

    ac97_slot_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .din        (sdata_in),
        .shift_next (shift_next)
    );

    assign unused_bits = ^shift_next[3:0];

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      prev_sync_q, prev_sync_d;
    logic [TAG_READY:TAG_SLOT4] tag_q, tag_d;
    logic [6:0]                addr_cand_q, addr_cand_d;
    logic [SAMPLE_BITS-1:0]    left_cand_q, left_cand_d;
    logic                      codec_ready_q, codec_ready_d;
    logic [6:0]                status_addr_q, status_addr_d;
    logic [15:0]               status_data_q, status_data_d;
    logic                      status_valid_q, status_valid_d;
    logic [SAMPLE_BITS-1:0]    pcm_left_q, pcm_left_d;
    logic [SAMPLE_BITS-1:0]    pcm_right_q, pcm_right_d;
    logic                      pcm_valid_q, pcm_valid_d;
    logic                      sync_err_q, sync_err_d;
    logic                      frame_start;
    logic                      decode_en;

    assign frame_start = sync && !prev_sync_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prev_sync_d    = prev_sync_q;
        tag_d          = tag_q;
        addr_cand_d    = addr_cand_q;
        left_cand_d    = left_cand_q;
        codec_ready_d  = codec_ready_q;
        status_addr_d  = status_addr_q;
        status_data_d  = status_data_q;
        pcm_left_d     = pcm_left_q;
        pcm_right_d    = pcm_right_q;
        status_valid_d = 1'b0;
        pcm_valid_d    = 1'b0;
        sync_err_d     = 1'b0;
        decode_en      = 1'b0;

        if (bit_en) begin
            prev_sync_d = sync;
            case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        state_d = LOCKED;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    // A counter of zero means a whole frame has elapsed: sync must rise now.
                    if (frame_start) begin
                        sync_err_d = (cnt_q != '0);
                        cnt_d      = CNT_W'(1);
                    end else if (cnt_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        decode_en = 1'b1;
                    end
                end
            endcase
        end

        if (decode_en) begin
            case (cnt_q)
                TAG_END: begin
                    tag_d         = shift_next[TAG_READY:TAG_SLOT4];
                    codec_ready_d = shift_next[TAG_READY];
                end
                SLOT1_END: begin
                    if (tag_q[TAG_SLOT1]) begin
                        addr_cand_d = shift_next[18:12];
                    end
                end
                SLOT2_END: begin
                    if (tag_q[TAG_SLOT1] && tag_q[TAG_SLOT2]) begin
                        status_addr_d  = addr_cand_q;
                        status_data_d  = shift_next[19:4];
                        status_valid_d = 1'b1;
                    end
                end
                SLOT3_END: begin
                    left_cand_d = shift_next[SLOT_BITS-1 -: SAMPLE_BITS];
                end
                SLOT4_END: begin
                    if (REQUIRE_BOTH != 0) begin
                        if (tag_q[TAG_SLOT3] && tag_q[TAG_SLOT4]) begin
                            pcm_left_d  = left_cand_q;
                            pcm_right_d = shift_next[SLOT_BITS-1 -: SAMPLE_BITS];
                            pcm_valid_d = 1'b1;
                        end
                    end else begin
                        if (tag_q[TAG_SLOT3]) begin
                            pcm_left_d = left_cand_q;
                        end
                        if (tag_q[TAG_SLOT4]) begin
                            pcm_right_d = shift_next[SLOT_BITS-1 -: SAMPLE_BITS];
                        end
                        pcm_valid_d = tag_q[TAG_SLOT3] || tag_q[TAG_SLOT4];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            prev_sync_q    <= 1'b0;
            tag_q          <= '0;
            addr_cand_q    <= '0;
            left_cand_q    <= '0;
            codec_ready_q  <= 1'b0;
            status_addr_q  <= '0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
            pcm_left_q     <= '0;
            pcm_right_q    <= '0;
            pcm_valid_q    <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_sync_q    <= prev_sync_d;
            tag_q          <= tag_d;
            addr_cand_q    <= addr_cand_d;
            left_cand_q    <= left_cand_d;
            codec_ready_q  <= codec_ready_d;
            status_addr_q  <= status_addr_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            pcm_left_q     <= pcm_left_d;
            pcm_right_q    <= pcm_right_d;
            pcm_valid_q    <= pcm_valid_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign codec_ready  = codec_ready_q;
    assign status_addr  = status_addr_q;
    assign status_data  = status_data_q;
    assign status_valid = status_valid_q;
    assign pcm_left     = pcm_left_q;
    assign pcm_right    = pcm_right_q;
    assign pcm_valid    = pcm_valid_q;
    assign sync_err     = sync_err_q;
    assign in_frame     = (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_ac97_record_rx.sv
// ============================================================================
// Module   : tb_ac97_record_rx
// Purpose  : Scoreboard bench for ac97_record_rx in both REQUIRE_BOTH modes
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ac97_record_rx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_en = 1'b0;
    logic sync = 1'b0;
    logic sdata_in = 1'b0;

    logic        a_codec_ready, a_pcm_valid, a_status_valid, a_sync_err, a_in_frame;
    logic [15:0] a_pcm_left, a_pcm_right, a_status_data;
    logic [6:0]  a_status_addr;
    logic        b_codec_ready, b_pcm_valid, b_status_valid, b_sync_err, b_in_frame;
    logic [15:0] b_pcm_left, b_pcm_right, b_status_data;
    logic [6:0]  b_status_addr;

    ac97_record_rx #(.SAMPLE_BITS(16), .REQUIRE_BOTH(1)) dut_a (
        .clk(clk), .reset(reset), .bit_en(bit_en), .sync(sync), .sdata_in(sdata_in),
        .codec_ready(a_codec_ready), .pcm_left(a_pcm_left), .pcm_right(a_pcm_right),
        .pcm_valid(a_pcm_valid), .status_addr(a_status_addr), .status_data(a_status_data),
        .status_valid(a_status_valid), .sync_err(a_sync_err), .in_frame(a_in_frame)
    );

    ac97_record_rx #(.SAMPLE_BITS(16), .REQUIRE_BOTH(0)) dut_b (
        .clk(clk), .reset(reset), .bit_en(bit_en), .sync(sync), .sdata_in(sdata_in),
        .codec_ready(b_codec_ready), .pcm_left(b_pcm_left), .pcm_right(b_pcm_right),
        .pcm_valid(b_pcm_valid), .status_addr(b_status_addr), .status_data(b_status_data),
        .status_valid(b_status_valid), .sync_err(b_sync_err), .in_frame(b_in_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [19:0] a;
        logic [19:0] b;
    } exp_t;

    exp_t q_stat[$];
    exp_t q_pcm_a[$];
    exp_t q_pcm_b[$];
    int   q_err[$];

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current frame plus expected held outputs.
    bit          m_bits[$];
    logic        m_prev_sync = 1'b0;
    logic        m_locked = 1'b0;
    logic        m_ready = 1'b0;
    logic [19:0] m_la = '0, m_ra = '0, m_lb = '0, m_rb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [19:0] field(input int start, input int len);
        logic [19:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v = {v[18:0], 1'(m_bits[start+i])};
        return v;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_prev_sync = 1'b0;
        m_locked = 1'b0;
        m_ready = 1'b0;
        m_la = '0; m_ra = '0; m_lb = '0; m_rb = '0;
    endtask

    // Called at a negedge: predict the response, then issue one bit_en strobe.
    task automatic drive_bit(input logic s, input logic d);
        exp_t e;
        int   n;
        if (s && !m_prev_sync) begin
            if (m_locked && m_bits.size() != 256) q_err.push_back(cyc + 1);
            m_locked = 1'b1;
            m_bits.delete();
        end else if (m_locked && m_bits.size() == 256) begin
            q_err.push_back(cyc + 1);
            m_locked = 1'b0;
            m_bits.delete();
        end
        m_prev_sync = s;
        if (m_locked) begin
            m_bits.push_back(d);
            n = m_bits.size();
            e.cyc = cyc + 1;
            if (n == 16) m_ready = m_bits[0];
            if (n == 56 && m_bits[1] && m_bits[2]) begin
                e.a = field(17, 7);
                e.b = field(36, 16);
                q_stat.push_back(e);
            end
            if (n == 96) begin
                if (m_bits[3] && m_bits[4]) begin
                    m_la = field(56, 16);
                    m_ra = field(76, 16);
                    e.a = m_la; e.b = m_ra;
                    q_pcm_a.push_back(e);
                end
                if (m_bits[3]) m_lb = field(56, 16);
                if (m_bits[4]) m_rb = field(76, 16);
                if (m_bits[3] || m_bits[4]) begin
                    e.a = m_lb; e.b = m_rb;
                    q_pcm_b.push_back(e);
                end
            end
        end
        sync = s;
        sdata_in = d;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                              input logic [19:0] s3, input logic [19:0] s4, input int nbits);
        logic [255:0] f;
        for (int k = 0; k < 5; k++) f[32*k +: 32] = $urandom;
        f[255:240] = tag;
        f[239:220] = s1;
        f[219:200] = s2;
        f[199:180] = s3;
        f[179:160] = s4;
        for (int i = 0; i < nbits; i++) drive_bit(i < 16, f[255-i]);
    endtask

    task automatic check_held(input string tag);
        check({tag, " a_pcm_left"},  {16'd0, a_pcm_left},  {12'd0, m_la});
        check({tag, " a_pcm_right"}, {16'd0, a_pcm_right}, {12'd0, m_ra});
        check({tag, " b_pcm_left"},  {16'd0, b_pcm_left},  {12'd0, m_lb});
        check({tag, " b_pcm_right"}, {16'd0, b_pcm_right}, {12'd0, m_rb});
        check({tag, " codec_ready"}, {31'd0, a_codec_ready}, {31'd0, m_ready});
        check({tag, " in_frame"},    {31'd0, a_in_frame},    {31'd0, m_locked});
    endtask

    // Monitor: every pulse must match the head of its queue on the predicted cycle.
    exp_t me;
    always @(negedge clk) begin
        if (q_stat.size() > 0 && q_stat[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL status_valid missing expected_cyc=%0d now=%0d", q_stat[0].cyc, cyc);
            void'(q_stat.pop_front());
        end
        if (q_stat.size() > 0 && q_stat[0].cyc == cyc) begin
            me = q_stat.pop_front();
            checks++;
            if (a_status_valid !== 1'b1 || {13'd0, a_status_addr} !== me.a || {4'd0, a_status_data} !== me.b) begin
                errors++;
                $display("FAIL status actual v=%b addr=%h data=%h required v=1 addr=%h data=%h",
                         a_status_valid, a_status_addr, a_status_data, me.a, me.b);
            end
        end else if (a_status_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL status_valid actual=%b required=0 at cyc %0d", a_status_valid, cyc);
        end

        if (q_pcm_a.size() > 0 && q_pcm_a[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL a_pcm_valid missing expected_cyc=%0d now=%0d", q_pcm_a[0].cyc, cyc);
            void'(q_pcm_a.pop_front());
        end
        if (q_pcm_a.size() > 0 && q_pcm_a[0].cyc == cyc) begin
            me = q_pcm_a.pop_front();
            checks++;
            if (a_pcm_valid !== 1'b1 || {4'd0, a_pcm_left} !== me.a || {4'd0, a_pcm_right} !== me.b) begin
                errors++;
                $display("FAIL a_pcm actual v=%b l=%h r=%h required v=1 l=%h r=%h",
                         a_pcm_valid, a_pcm_left, a_pcm_right, me.a, me.b);
            end
        end else if (a_pcm_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL a_pcm_valid actual=%b required=0 at cyc %0d", a_pcm_valid, cyc);
        end

        if (q_pcm_b.size() > 0 && q_pcm_b[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL b_pcm_valid missing expected_cyc=%0d now=%0d", q_pcm_b[0].cyc, cyc);
            void'(q_pcm_b.pop_front());
        end
        if (q_pcm_b.size() > 0 && q_pcm_b[0].cyc == cyc) begin
            me = q_pcm_b.pop_front();
            checks++;
            if (b_pcm_valid !== 1'b1 || {4'd0, b_pcm_left} !== me.a || {4'd0, b_pcm_right} !== me.b) begin
                errors++;
                $display("FAIL b_pcm actual v=%b l=%h r=%h required v=1 l=%h r=%h",
                         b_pcm_valid, b_pcm_left, b_pcm_right, me.a, me.b);
            end
        end else if (b_pcm_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL b_pcm_valid actual=%b required=0 at cyc %0d", b_pcm_valid, cyc);
        end

        if (q_err.size() > 0 && q_err[0] < cyc) begin
            checks++; errors++;
            $display("FAIL sync_err missing expected_cyc=%0d now=%0d", q_err[0], cyc);
            void'(q_err.pop_front());
        end
        if (q_err.size() > 0 && q_err[0] == cyc) begin
            void'(q_err.pop_front());
            check("sync_err pulse", {31'd0, a_sync_err}, 32'd1);
        end else if (a_sync_err !== 1'b0) begin
            checks++; errors++;
            $display("FAIL sync_err actual=%b required=0 at cyc %0d", a_sync_err, cyc);
        end
    end

    initial begin
        // Reset with activity on the inputs
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sync = 1'(i);
            sdata_in = ~1'(i);
            bit_en = 1'b1;
        end
        @(negedge clk);
        bit_en = 1'b0;
        check("rst in_frame",    {31'd0, a_in_frame}, 32'd0);
        check("rst codec_ready", {31'd0, a_codec_ready}, 32'd0);
        check("rst pcm_left",    {16'd0, a_pcm_left}, 32'd0);
        check("rst status_data", {16'd0, a_status_data}, 32'd0);
        check("rst pulses",      {29'd0, a_pcm_valid, a_status_valid, a_sync_err}, 32'd0);
        sync = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Idle: no sync rise, no pulses
        for (int i = 0; i < 300; i++) drive_bit(1'b0, 1'($urandom));
        check("idle in_frame", {31'd0, a_in_frame}, 32'd0);

        // Nominal frame followed by a partially tagged frame
        send_frame(16'hF800, 20'h26000, 20'h12340, 20'hABCD0, 20'h12345, 256);
        check("nom status_addr", {25'd0, a_status_addr}, 32'h26);
        check("nom status_data", {16'd0, a_status_data}, 32'h1234);
        check("nom pcm_left",    {16'd0, a_pcm_left},  32'hABCD);
        check("nom pcm_right",   {16'd0, a_pcm_right}, 32'h1234);
        check_held("nom");

        send_frame(16'h9000, 20'h11111, 20'h22222, 20'h55550, 20'h77770, 256);
        check("part a_pcm_left",  {16'd0, a_pcm_left},  32'hABCD);
        check("part b_pcm_left",  {16'd0, b_pcm_left},  32'h5555);
        check("part b_pcm_right", {16'd0, b_pcm_right}, 32'h1234);
        check("part status_addr", {25'd0, a_status_addr}, 32'h26);
        check_held("part");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            send_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256);
            check_held("rand");
        end

        // Early sync at bit 120
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 120);
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256);
        check("early in_frame", {31'd0, a_in_frame}, 32'd1);
        check_held("early");

        // Missing sync at the boundary, then relock
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'($urandom));
        check("miss in_frame", {31'd0, a_in_frame}, 32'd0);
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256);
        send_frame(16'hD800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256);
        check_held("relock");

        // Asynchronous reset at bit 80
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 81);
        #2 reset = 1'b0;
        #1;
        check("mid rst pcm_left",   {16'd0, a_pcm_left}, 32'd0);
        check("mid rst status",     {16'd0, a_status_data}, 32'd0);
        check("mid rst in_frame",   {31'd0, a_in_frame}, 32'd0);
        check("mid rst ready",      {31'd0, a_codec_ready}, 32'd0);
        model_reset();
        sync = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(16'hF800, 20'h5A000, 20'hCAFE0, 20'h13570, 20'h24680, 256);
        check("post rst pcm_left",  {16'd0, a_pcm_left},  32'h1357);
        check("post rst pcm_right", {16'd0, a_pcm_right}, 32'h2468);
        check("post rst status",    {16'd0, a_status_data}, 32'hCAFE);
        check_held("post");

        repeat (8) @(negedge clk);
        check("queues drained", q_stat.size() + q_pcm_a.size() + q_pcm_b.size() + q_err.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
